spmv_stream_engine: RTL and testbench



---
 rtl/spmv_pkg.sv | 37 +++
 rtl/spmv_ffs.sv | 23 ++
 rtl/spmv_stream_engine.sv | 155 +++++++++++++++
 tb/tb_spmv_stream_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared state type, default sizes and signed-aware arithmetic helpers
package spmv_pkg;

    localparam int DIM_DEF    = 32;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 21;
    // Helpers operate at this fixed width, so ACC_W must stay below it
    localparam int FN_W       = 64;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_VEC, ST_LOAD_MAT, ST_DRAIN} state_t;

    function automatic logic [FN_W-1:0] ext_val(input logic [FN_W-1:0] v, input int w, input bit sgn);
        logic [FN_W-1:0] mask;
        logic            msb;
        mask = (FN_W'(1) << w) - FN_W'(1);
        msb  = |(v & (FN_W'(1) << (w - 1)));
        if (sgn && msb) return v | ~mask;
        return v & mask;
    endfunction

    function automatic logic [FN_W-1:0] acc_add(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b,
                                                input int w, input bit sgn, input bit sat);
        logic [FN_W-1:0] mask, top, sum;
        logic            sa, sb, ss;
        mask = (FN_W'(1) << w) - FN_W'(1);
        top  = FN_W'(1) << (w - 1);
        sum  = (a & mask) + (b & mask);
        sa   = |(a & top);
        sb   = |(b & top);
        ss   = |(sum & top);
        if (!sat) return sum & mask;
        if (!sgn) return ((sum & ~mask) != '0) ? mask : sum;
        if ((sa == sb) && (ss != sa)) return sa ? top : top - FN_W'(1);
        return sum & mask;
    endfunction

endpackage

// File: rtl/spmv_ffs.sv
// rtl/spmv_ffs.sv - lowest-set-bit finder with any-set and more-than-one-set flags
module spmv_ffs #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  flags,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (flags[i]) idx = IW'(i);
        end
    end

    assign any   = |flags;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi = |(flags & (flags - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/spmv_stream_engine.sv
// rtl/spmv_stream_engine.sv - sparse matrix x sparse vector engine with ready/valid result drain
// Optional SPMV_SATURATE_EN: accumulators clamp at their rails instead of wrapping.
module spmv_stream_engine
    import spmv_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 0,
    localparam int IDX_W = $clog2(DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              weight_valid,
    input  logic [IDX_W-1:0]  in_row,
    input  logic [IDX_W-1:0]  in_col,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_row,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_finish,
    output logic              err
);

`ifdef SPMV_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam bit             SGN   = (SIGNED != 0);
    localparam logic [IDX_W:0] DIM_L = (IDX_W + 1)'(DIM);

    state_t              state, state_nx;
    logic [DATA_W-1:0]   vec [DIM];
    logic [DIM-1:0]      vvalid;
    logic [ACC_W-1:0]    acc [DIM];
    logic [DIM-1:0]      flags;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_vec, s1_w;
    logic [IDX_W-1:0]    s1_row;
    logic [2*DATA_W-1:0] prod;
    logic [FN_W-1:0]     sum_w;
    logic [ACC_W-1:0]    acc_nx;
    logic                unused_sum_hi;
    logic [IDX_W-1:0]    ffs_idx;
    logic                ffs_any, ffs_multi;
    logic                row_ok, col_ok, vec_wr, mat_wr, proto_err, drain_load, finish_hs;

    assign row_ok    = {1'b0, in_row} < DIM_L;
    assign col_ok    = {1'b0, in_col} < DIM_L;
    assign finish_hs = out_valid && out_ready && out_finish;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (weight_valid) state_nx = ST_LOAD_MAT;
                         else if (in_valid) state_nx = ST_LOAD_VEC;
            ST_LOAD_VEC: if (weight_valid) state_nx = ST_LOAD_MAT;
            ST_LOAD_MAT: if (!weight_valid) state_nx = ST_DRAIN;
            ST_DRAIN:    if (finish_hs) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state != ST_DRAIN);
        mat_wr     = in_ready && weight_valid && row_ok && col_ok;
        vec_wr     = in_ready && in_valid && !weight_valid && (state != ST_LOAD_MAT) && row_ok;
        // Any sampled beat that was not consumed is a protocol violation
        proto_err  = in_ready && ((in_valid && !vec_wr) || (weight_valid && !mat_wr));
        drain_load = (state == ST_DRAIN) && (!out_valid || (out_ready && !out_finish));
    end

    always_ff @(posedge clk) begin
        if (rst || finish_hs) begin
            for (int i = 0; i < DIM; i++) vec[i] <= '0;
            vvalid <= '0;
        end else if (vec_wr) begin
            vec[in_row]    <= in_data;
            vvalid[in_row] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
            s1_w     <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= mat_wr;
            if (mat_wr) begin
                s1_vec <= vvalid[in_col] ? vec[in_col] : '0;
                s1_w   <= in_data;
                s1_row <= in_row;
            end
        end
    end

    // Operands are pre-extended so one unsigned multiply gives the right low product bits
    assign prod = {{DATA_W{SGN & s1_vec[DATA_W-1]}}, s1_vec} * {{DATA_W{SGN & s1_w[DATA_W-1]}}, s1_w};

    always_comb begin
        sum_w = acc_add({{(FN_W-ACC_W){1'b0}}, acc[s1_row]},
                        ext_val({{(FN_W-2*DATA_W){1'b0}}, prod}, 2 * DATA_W, SGN),
                        ACC_W, SGN, SAT_EN);
        acc_nx        = sum_w[ACC_W-1:0];
        unused_sum_hi = ^sum_w[FN_W-1:ACC_W];
        for (int i = 0; i < DIM; i++) flags[i] = |acc[i];
    end

    spmv_ffs #(.N(DIM), .IW(IDX_W)) u_ffs (
        .flags (flags),
        .idx   (ffs_idx),
        .any   (ffs_any),
        .multi (ffs_multi)
    );

    // A row's sum moves into the output register when captured, so its accumulator is free at once
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) acc[i] <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_data   <= '0;
            out_finish <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (s1_valid) acc[s1_row] <= acc_nx;
            if (drain_load) begin
                out_valid    <= 1'b1;
                out_row      <= ffs_any ? ffs_idx : '0;
                out_data     <= acc[ffs_idx];
                out_finish   <= !ffs_multi;
                acc[ffs_idx] <= '0;
            end else if (finish_hs) begin
                out_valid  <= 1'b0;
                out_row    <= '0;
                out_data   <= '0;
                out_finish <= 1'b0;
            end
            if (finish_hs)      err <= 1'b0;
            else if (proto_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spmv_stream_engine.sv
// tb/tb_spmv_stream_engine.sv - scoreboard bench: unsigned, signed and 16-bit accumulator instances
module tb_spmv_stream_engine;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] data;
        logic        fin;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, iv, wv, ordy;
    logic [1:0]  sel;
    logic [4:0]  row, col;
    logic [7:0]  data;
    logic        ir0, ov0, of0, er0, ir1, ov1, of1, er1, ir2, ov2, of2, er2;
    logic [4:0]  or0, or1, or2;
    logic [20:0] od0, od1;
    logic [15:0] od2;
    int          errors = 0;
    int          checks = 0;
    beat_t       q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    spmv_stream_engine u0 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 2'd0), .weight_valid(wv && sel == 2'd0),
        .in_row(row), .in_col(col), .in_data(data), .in_ready(ir0), .out_valid(ov0),
        .out_ready(ordy), .out_row(or0), .out_data(od0), .out_finish(of0), .err(er0));

    spmv_stream_engine #(.SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 2'd1), .weight_valid(wv && sel == 2'd1),
        .in_row(row), .in_col(col), .in_data(data), .in_ready(ir1), .out_valid(ov1),
        .out_ready(ordy), .out_row(or1), .out_data(od1), .out_finish(of1), .err(er1));

    spmv_stream_engine #(.ACC_W(16)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv && sel == 2'd2), .weight_valid(wv && sel == 2'd2),
        .in_row(row), .in_col(col), .in_data(data), .in_ready(ir2), .out_valid(ov2),
        .out_ready(ordy), .out_row(or2), .out_data(od2), .out_finish(of2), .err(er2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int r, input logic [31:0] v, input logic f);
        beat_t e;
        e.row = 32'(r);
        e.data = v;
        e.fin = f;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic busy(input int d);
        case (d)
            0: return ov0 || !ir0;
            1: return ov1 || !ir1;
            default: return ov2 || !ir2;
        endcase
    endfunction

    task automatic pop_chk(input int d, input logic [31:0] r, input logic [31:0] v, input logic f,
                           input logic irdy);
        beat_t e;
        bit    have;
        have = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL extra_beat dut%0d: got row %0d data %0h, required no beat", d, r, v);
        end else begin
            chk($sformatf("out_row dut%0d", d), r, e.row);
            chk($sformatf("out_data dut%0d row %0d", d, e.row), v, e.data);
            chk($sformatf("out_finish dut%0d row %0d", d, e.row), 32'(f), 32'(e.fin));
            chk($sformatf("in_ready_in_drain dut%0d", d), 32'(irdy), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (ov0 && ordy) pop_chk(0, 32'(or0), 32'(od0), of0, ir0);
        if (ov1 && ordy) pop_chk(1, 32'(or1), 32'(od1), of1, ir1);
        if (ov2 && ordy) pop_chk(2, 32'(or2), 32'(od2), of2, ir2);
    end

    task automatic vbeat(input int r, input int d);
        iv = 1'b1;
        row = 5'(r);
        data = 8'(d);
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic wbeat(input int r, input int c, input int d);
        wv = 1'b1;
        row = 5'(r);
        col = 5'(c);
        data = 8'(d);
        @(posedge clk);
        #1;
        wv = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        ordy = 1'b1;
        while ((qsize(d) != 0 || busy(d)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_completes dut%0d", d), 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [3:0] pat;
        logic [31:0] sat_exp;
        rst = 1'b1; iv = 1'b0; wv = 1'b0; ordy = 1'b1; sel = 2'd0;
        row = '0; col = '0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset out_finish", 32'(of0), 32'd0);
        chk("reset out_data", 32'(od0), 32'd0);
        chk("reset err", 32'(er0), 32'd0);
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid u2", 32'(ov2), 32'd0);

        // Two rows, two terms in row 1, plus output latency
        push(0, 1, 34, 1'b0);
        push(0, 7, 8, 1'b1);
        vbeat(2, 3);
        vbeat(5, 4);
        wbeat(1, 2, 10);
        wbeat(1, 5, 1);
        wbeat(7, 5, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov0 && n < 20);
        chk("first_valid_latency", 32'(n), 32'd3);
        drain(0);

        // Same row back-to-back, vector entry overwritten first
        push(0, 3, 120, 1'b1);
        vbeat(2, 9);
        vbeat(2, 6);
        repeat (4) wbeat(3, 2, 5);
        drain(0);

        // Backpressure during a three-row drain
        ordy = 1'b0;
        push(0, 4, 5, 1'b0);
        push(0, 9, 7, 1'b0);
        push(0, 20, 9, 1'b1);
        vbeat(0, 1);
        wbeat(4, 0, 5);
        wbeat(9, 0, 7);
        wbeat(20, 0, 9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov0 && n < 20);
        chk("stall first valid seen", 32'(ov0), 32'd1);
        pat = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            ordy = pat[k];
            @(negedge clk);
            if (!pat[k]) begin
                chk("stall held out_valid", 32'(ov0), 32'd1);
                chk("stall held out_row", 32'(or0), 32'd9);
                chk("stall held out_data", 32'(od0), 32'd7);
                chk("stall in_ready", 32'(ir0), 32'd0);
            end
        end
        drain(0);

        // Signed: products cancel, then a negative sum
        sel = 2'd1;
        push(1, 0, 0, 1'b1);
        vbeat(0, 8'h80);
        wbeat(4, 0, 127);
        wbeat(4, 0, 8'h81);
        drain(1);
        push(1, 6, 32'h1FFFF6, 1'b1);
        vbeat(3, 8'hFE);
        wbeat(6, 3, 5);
        drain(1);

        // Weights without a vector, then simultaneous beats
        sel = 2'd0;
        push(0, 0, 0, 1'b1);
        wbeat(2, 3, 7);
        chk("err clean weights only", 32'(er0), 32'd0);
        drain(0);
        push(0, 0, 0, 1'b1);
        iv = 1'b1; wv = 1'b1; row = 5'd5; col = 5'd1; data = 8'd9;
        @(posedge clk);
        #1;
        iv = 1'b0; wv = 1'b0;
        chk("err set on collision", 32'(er0), 32'd1);
        drain(0);
        chk("err cleared in idle", 32'(er0), 32'd0);
        chk("in_ready in idle", 32'(ir0), 32'd1);

        // Reset mid-job discards partial sums
        vbeat(1, 1);
        wbeat(3, 1, 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midjob reset out_valid", 32'(ov0), 32'd0);
        chk("midjob reset in_ready", 32'(ir0), 32'd1);
        push(0, 3, 2, 1'b1);
        vbeat(1, 2);
        wbeat(3, 1, 1);
        drain(0);

        // 16-bit accumulator overflow
        sel = 2'd2;
`ifdef SPMV_SATURATE_EN
        sat_exp = 32'hFFFF;
`else
        sat_exp = 32'hFC02;
`endif
        push(2, 0, sat_exp, 1'b1);
        vbeat(0, 255);
        wbeat(0, 0, 255);
        wbeat(0, 0, 255);
        drain(2);

        chk("scoreboard empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
